// File: rtl/exe_div_unit.sv
// Iterative 32-bit restoring divider for the EXE stage.
// Signed/unsigned, 33-cycle latency, stalls the front end while busy.
module exe_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_div,
  input  logic        is_sign_div,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic        cancel,
  output logic        div_stall,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        result_valid
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        s0_q, s0_d;
  logic        s1_q, s1_d;
  logic        sg_q, sg_d;

  logic        start;
  logic [32:0] part;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] a_abs;
  logic [31:0] b_abs;

  assign start  = (state_q == IDLE) && is_div && !cancel;
  assign part   = {rem_q, dvd_q[31]};
  assign diff   = part - {1'b0, dvs_q};
  assign qbit   = ~diff[32];
  assign rem_nx = qbit ? diff[31:0] : part[31:0];
  assign quo_nx = {quo_q[30:0], qbit};
  assign a_abs  = (is_sign_div && src0[31]) ? -src0 : src0;
  assign b_abs  = (is_sign_div && src1[31]) ? -src1 : src1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    sg_d    = sg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          s0_d  = src0[31];
          s1_d  = src1[31];
          sg_d  = is_sign_div;
          dvd_d = a_abs;
          dvs_d = b_abs;
          quo_d = '0;
          rem_d = '0;
          cnt_d = '0;
          // Divide by zero skips iteration; result is raw, uncorrected
          if (src1 == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = src0;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          dvd_d = {dvd_q[30:0], 1'b0};
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DONE;
            q_d = (sg_q && (s0_q ^ s1_q)) ? -quo_nx : quo_nx;
            r_d = (sg_q && s0_q) ? -rem_nx : rem_nx;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      sg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      sg_q    <= sg_d;
    end
  end

  assign div_stall    = rst_n && !cancel && (start || (state_q == BUSY));
  assign result_valid = (state_q == DONE) && !cancel;
  assign quotient     = q_q;
  assign remainder    = r_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed bench for exe_div_unit: unsigned/signed divides, div-by-zero,
// overflow wrap, cancel, back-to-back and mid-operation reset.
module tb_exe_div_unit;

  logic        clk;
  logic        rst_n;
  logic        is_div;
  logic        is_sign_div;
  logic [31:0] src0;
  logic [31:0] src1;
  logic        cancel;
  logic        div_stall;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        result_valid;

  int compared;
  int mismatched;

  exe_div_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .is_div       (is_div),
    .is_sign_div  (is_sign_div),
    .src0         (src0),
    .src1         (src1),
    .cancel       (cancel),
    .div_stall    (div_stall),
    .quotient     (quotient),
    .remainder    (remainder),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a divide and holds it until result_valid (as a stalled
  // ID/EXE register would). Returns latency in cycles (-1 on timeout)
  // and number of stalled cycles before the result.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic sg, output int lat, output int stalls,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic st_done);
    logic done;
    src0 = a;
    src1 = b;
    is_sign_div = sg;
    is_div = 1'b1;
    lat = -1;
    stalls = 0;
    q = 'x;
    r = 'x;
    st_done = 1'bx;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (result_valid) begin
        done = 1'b1;
        lat = i;
        q = quotient;
        r = remainder;
        st_done = div_stall;
      end else if (div_stall) begin
        stalls++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int          lat;
  int          stalls;
  logic [31:0] q;
  logic [31:0] r;
  logic        sd;
  logic [31:0] prev_q;
  logic [31:0] prev_r;
  int          vcount;
  int          qchg;

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;
    is_div = 1'b1;
    is_sign_div = 1'b0;
    src0 = 32'd100;
    src1 = 32'd7;
    cancel = 1'b0;
    #12;
    chk("rst_stall", {31'd0, div_stall}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    is_div = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 100/7 unsigned, then 9/2 back-to-back
    run_div(32'd100, 32'd7, 1'b0, lat, stalls, q, r, sd);
    chk("u100_lat", lat, 32'd33);
    chk("u100_stalls", stalls, 32'd33);
    chk("u100_q", q, 32'd14);
    chk("u100_r", r, 32'd2);
    chk("u100_stall_done", {31'd0, sd}, 32'd0);
    run_div(32'd9, 32'd2, 1'b0, lat, stalls, q, r, sd);
    chk("b2b_lat", lat, 32'd33);
    chk("b2b_q", q, 32'd4);
    chk("b2b_r", r, 32'd1);
    is_div = 1'b0;
    @(negedge clk);
    chk("valid_pulse", {31'd0, result_valid}, 32'd0);
    @(posedge clk);
    #1;

    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, stalls, q, r, sd);
    chk("s_m7_2_q", q, 32'hFFFF_FFFD);
    chk("s_m7_2_r", r, 32'hFFFF_FFFF);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, lat, stalls, q, r, sd);
    chk("s_7_m2_q", q, 32'hFFFF_FFFD);
    chk("s_7_m2_r", r, 32'd1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, stalls, q, r, sd);
    chk("s_ovf_lat", lat, 32'd33);
    chk("s_ovf_q", q, 32'h8000_0000);
    chk("s_ovf_r", r, 32'd0);
    run_div(32'hFFFF_FFFF, 32'h10, 1'b0, lat, stalls, q, r, sd);
    chk("u_big_q", q, 32'h0FFF_FFFF);
    chk("u_big_r", r, 32'hF);

    run_div(32'd5, 32'd0, 1'b0, lat, stalls, q, r, sd);
    chk("dz_lat", lat, 32'd1);
    chk("dz_stalls", stalls, 32'd1);
    chk("dz_q", q, 32'hFFFF_FFFF);
    chk("dz_r", r, 32'd5);
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, lat, stalls, q, r, sd);
    chk("sdz_q", q, 32'hFFFF_FFFF);
    chk("sdz_r", r, 32'hFFFF_FFFB);
    is_div = 1'b0;
    @(posedge clk);
    #1;

    // cancel wins over start in IDLE
    src0 = 32'd50;
    src1 = 32'd5;
    is_sign_div = 1'b0;
    is_div = 1'b1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_idle_stall", {31'd0, div_stall}, 32'd0);
    @(posedge clk);
    #1;
    is_div = 1'b0;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_idle_state", {31'd0, div_stall}, 32'd0);
    @(posedge clk);
    #1;

    // cancel while BUSY with counter=10
    prev_q = quotient;
    prev_r = remainder;
    src0 = 32'd1000;
    src1 = 32'd7;
    is_div = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_busy_stall", {31'd0, div_stall}, 32'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    is_div = 1'b0;
    vcount = 0;
    qchg = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) vcount++;
      if (div_stall) vcount++;
      if (quotient !== prev_q || remainder !== prev_r) qchg++;
    end
    chk("cancel_no_valid", vcount, 32'd0);
    chk("cancel_hold_qr", qchg, 32'd0);
    @(posedge clk);
    #1;
    run_div(32'd9, 32'd3, 1'b0, lat, stalls, q, r, sd);
    chk("post_cancel_q", q, 32'd3);
    chk("post_cancel_r", r, 32'd0);

    // reset mid-BUSY
    src0 = 32'd100;
    src1 = 32'd7;
    is_div = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_q", quotient, 32'd0);
    chk("mrst_r", remainder, 32'd0);
    chk("mrst_valid", {31'd0, result_valid}, 32'd0);
    chk("mrst_stall", {31'd0, div_stall}, 32'd0);
    is_div = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_idle", {31'd0, div_stall}, 32'd0);
    @(posedge clk);
    #1;
    run_div(32'd100, 32'd7, 1'b0, lat, stalls, q, r, sd);
    chk("mrst_lat", lat, 32'd33);
    chk("mrst_q2", q, 32'd14);
    chk("mrst_r2", r, 32'd2);
    is_div = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/exe_div_unit.md
EXE_DIV_UNIT -- requirements
Module: exe_div_unit

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL provide port is_div, input, 1 bit: the instruction now in EXE is a divide (taken from the ID/EXE stage register).
REQ-004 SHALL provide port is_sign_div, input, 1 bit: 1 = signed divide, 0 = unsigned divide.
REQ-005 SHALL provide port src0, input, 32 bits: dividend.
REQ-006 SHALL provide port src1, input, 32 bits: divisor.
REQ-007 SHALL provide port cancel, input, 1 bit: EXE flush or exception; abandons any divide in flight.
REQ-008 SHALL provide port div_stall, output, 1 bit: stall request to PC, IF/ID and ID/EXE while a divide is unfinished.
REQ-009 SHALL provide port quotient, output, 32 bits: result destined for LO.
REQ-010 SHALL provide port remainder, output, 32 bits: result destined for HI.
REQ-011 SHALL provide port result_valid, output, 1 bit: one-cycle pulse when quotient and remainder hold a new result.

Function
REQ-012 SHALL implement three states: IDLE, BUSY, DONE.
REQ-013 In IDLE, with is_div=1 and cancel=0, SHALL do all of the following:
- latch |src0|, |src1| (absolute values only when is_sign_div=1) and both sign bits;
- clear the iteration counter (5 bits);
- go to BUSY, or go to DONE if src1=0.
REQ-014 In BUSY, SHALL perform one restoring shift-subtract step per cycle using a 33-bit partial remainder; after iteration 31 (counter=31) SHALL go to DONE.
REQ-015 Start-to-result latency SHALL be 33 cycles: start edge T, 32 BUSY cycles, DONE state entered at T+33.
REQ-016 div_stall SHALL be combinational:
- 1 when (state=IDLE and is_div=1 and cancel=0) or state=BUSY;
- 0 in DONE and whenever cancel=1.
REQ-017 On entering DONE, SHALL register the signed-corrected result into quotient and remainder:
- quotient negated when is_sign_div=1 and the operand signs differ;
- remainder negated when is_sign_div=1 and the dividend is negative.
REQ-018 result_valid SHALL be 1 for exactly the single cycle the FSM is in DONE; DONE SHALL always go to IDLE next cycle.
REQ-019 Divide by zero SHALL produce quotient=0xFFFFFFFF and remainder=src0 (raw), with no sign correction.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL wrap to quotient=0x80000000, remainder=0.
REQ-021 quotient and remainder SHALL hold their values outside DONE entry and SHALL NOT change on cancel.
REQ-022 cancel=1 in BUSY or DONE SHALL force IDLE on the next edge with no result_valid pulse; cancel SHALL have priority over start.
REQ-023 A divide seen in IDLE on the cycle after DONE SHALL start a new operation (back-to-back divides).

Reset
REQ-024 rst_n=0 SHALL immediately force the following, regardless of the current state (including mid-BUSY):
- state=IDLE, counter=0;
- quotient=0, remainder=0, result_valid=0, all internal operand registers 0.
REQ-025 While rst_n=0, div_stall SHALL be 0.

Verification
REQ-026 Unsigned: src0=100, src1=7 -> div_stall high for 33 cycles; result_valid at T+33 with quotient=14, remainder=2.
REQ-027 Signed: src0=0xFFFFFFF9 (-7), src1=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-028 Signed: 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, with no hang or X.
REQ-029 Unsigned 5/0 -> div_stall high 1 cycle, DONE at T+1, quotient=0xFFFFFFFF, remainder=5.
REQ-030 Cancel: cancel=1 at BUSY counter=10 -> IDLE next cycle, no result_valid, prior quotient/remainder unchanged; a following divide of 9/3 returns quotient=3, remainder=0.
REQ-031 Reset: rst_n low mid-BUSY -> outputs 0, state IDLE immediately; after release, 100/7 completes correctly.
